// File: rtl/ram_nr_mw.sv
// Multi-port register array with per-entry busy scoreboard, write-to-read bypass
// and an optional hardwired-zero entry 0.
module ram_nr_mw #(
    parameter int unsigned OPRAND_WIDTH  = 32,
    parameter int unsigned ARRAY_ENTRY   = 32,
    parameter int unsigned REGNAME_WIDTH = 5,
    parameter int unsigned NUM_READ      = 3,
    parameter int unsigned NUM_WRITE     = 2,
    parameter int unsigned NUM_ALLOC     = 1,
    parameter int unsigned BYPASS        = 1,
    parameter int unsigned ZERO_ENTRY    = 0,
    localparam int unsigned CountWidth   = $clog2(ARRAY_ENTRY + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_WRITE-1:0]              write_en_i,
    input  logic [NUM_WRITE*REGNAME_WIDTH-1:0] write_addr_i,
    input  logic [NUM_WRITE*OPRAND_WIDTH-1:0]  write_data_i,
    input  logic [NUM_ALLOC-1:0]              alloc_en_i,
    input  logic [NUM_ALLOC*REGNAME_WIDTH-1:0] alloc_addr_i,
    input  logic [NUM_READ-1:0]               read_en_i,
    input  logic [NUM_READ*REGNAME_WIDTH-1:0]  read_addr_i,
    output logic [NUM_READ*OPRAND_WIDTH-1:0]   read_data_o,
    output logic [NUM_READ-1:0]               read_ready_o,
    output logic [CountWidth-1:0]             busy_count_o
);

    logic [OPRAND_WIDTH-1:0]  data_q [ARRAY_ENTRY];
    logic [OPRAND_WIDTH-1:0]  data_d [ARRAY_ENTRY];
    logic [ARRAY_ENTRY-1:0]   busy_q, busy_d;
    logic [CountWidth-1:0]    busy_count_q, busy_count_d;

    logic [REGNAME_WIDTH-1:0] waddr [NUM_WRITE];
    logic [OPRAND_WIDTH-1:0]  wdata [NUM_WRITE];
    logic [REGNAME_WIDTH-1:0] aaddr [NUM_ALLOC];
    logic [REGNAME_WIDTH-1:0] raddr [NUM_READ];

    // False only for entry 0 when it is hardwired to zero.
    function automatic logic addr_ok(input logic [REGNAME_WIDTH-1:0] a);
        return !((ZERO_ENTRY != 0) && (a == '0));
    endfunction

    always_comb begin
        for (int w = 0; w < NUM_WRITE; w++) begin
            waddr[w] = write_addr_i[w*REGNAME_WIDTH +: REGNAME_WIDTH];
            wdata[w] = write_data_i[w*OPRAND_WIDTH +: OPRAND_WIDTH];
        end
        for (int a = 0; a < NUM_ALLOC; a++) begin
            aaddr[a] = alloc_addr_i[a*REGNAME_WIDTH +: REGNAME_WIDTH];
        end
        for (int r = 0; r < NUM_READ; r++) begin
            raddr[r] = read_addr_i[r*REGNAME_WIDTH +: REGNAME_WIDTH];
        end
    end

    // Ascending port order lets the highest write port win; allocates are applied
    // after writes so they win the busy bit on a collision.
    always_comb begin
        data_d = data_q;
        busy_d = busy_q;
        for (int w = 0; w < NUM_WRITE; w++) begin
            if (write_en_i[w] && addr_ok(waddr[w])) begin
                data_d[waddr[w]] = wdata[w];
                busy_d[waddr[w]] = 1'b0;
            end
        end
        for (int a = 0; a < NUM_ALLOC; a++) begin
            if (alloc_en_i[a] && addr_ok(aaddr[a])) begin
                busy_d[aaddr[a]] = 1'b1;
            end
        end
        busy_count_d = '0;
        for (int i = 0; i < ARRAY_ENTRY; i++) begin
            busy_count_d = busy_count_d + CountWidth'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARRAY_ENTRY; i++) begin
                data_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            data_q       <= data_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    always_comb begin
        read_data_o  = '0;
        read_ready_o = '0;
        for (int r = 0; r < NUM_READ; r++) begin
            if (read_en_i[r]) begin
                if (!addr_ok(raddr[r])) begin
                    read_ready_o[r] = 1'b1;
                end else begin
                    read_data_o[r*OPRAND_WIDTH +: OPRAND_WIDTH] = data_q[raddr[r]];
                    read_ready_o[r] = !busy_q[raddr[r]];
                    if (BYPASS != 0) begin
                        for (int w = 0; w < NUM_WRITE; w++) begin
                            if (write_en_i[w] && (waddr[w] == raddr[r])) begin
                                read_data_o[r*OPRAND_WIDTH +: OPRAND_WIDTH] = wdata[w];
                                read_ready_o[r] = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign busy_count_o = busy_count_q;

endmodule

// File: tb/tb_ram_nr_mw.sv
// Bench for ram_nr_mw: instance 0 has bypass and no zero entry, instance 1 has
// a hardwired zero entry and no bypass; both are checked against an array model.
module tb_ram_nr_mw;

    localparam int W  = 32;
    localparam int E  = 32;
    localparam int AW = 5;
    localparam int NR = 3;
    localparam int NW = 2;
    localparam int NA = 1;
    localparam int CW = 6;

    logic            clk;
    logic            rst;
    logic [NW-1:0]   wen;
    logic [NW*AW-1:0] waddr;
    logic [NW*W-1:0]  wdata;
    logic [NA-1:0]   aen;
    logic [NA*AW-1:0] aaddr;
    logic [NR-1:0]   ren;
    logic [NR*AW-1:0] raddr;

    logic [NR*W-1:0] rd0, rd1;
    logic [NR-1:0]   rr0, rr1;
    logic [CW-1:0]   bc0, bc1;

    int n_checks = 0;
    int n_errors = 0;

    ram_nr_mw #(
        .OPRAND_WIDTH(W), .ARRAY_ENTRY(E), .REGNAME_WIDTH(AW), .NUM_READ(NR),
        .NUM_WRITE(NW), .NUM_ALLOC(NA), .BYPASS(1), .ZERO_ENTRY(0)
    ) u_dut0 (
        .clk(clk), .rst(rst),
        .write_en_i(wen), .write_addr_i(waddr), .write_data_i(wdata),
        .alloc_en_i(aen), .alloc_addr_i(aaddr),
        .read_en_i(ren), .read_addr_i(raddr),
        .read_data_o(rd0), .read_ready_o(rr0), .busy_count_o(bc0)
    );

    ram_nr_mw #(
        .OPRAND_WIDTH(W), .ARRAY_ENTRY(E), .REGNAME_WIDTH(AW), .NUM_READ(NR),
        .NUM_WRITE(NW), .NUM_ALLOC(NA), .BYPASS(0), .ZERO_ENTRY(1)
    ) u_dut1 (
        .clk(clk), .rst(rst),
        .write_en_i(wen), .write_addr_i(waddr), .write_data_i(wdata),
        .alloc_en_i(aen), .alloc_addr_i(aaddr),
        .read_en_i(ren), .read_addr_i(raddr),
        .read_data_o(rd1), .read_ready_o(rr1), .busy_count_o(bc1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_data [2][E];
    bit           m_busy [2][E];
    bit           model_valid = 1'b0;

    function automatic bit has_zero(input int z);
        return z == 1;
    endfunction

    function automatic bit has_bypass(input int z);
        return z == 0;
    endfunction

    function automatic int model_count(input int z);
        int n = 0;
        for (int e = 0; e < E; e++) n += int'(m_busy[z][e]);
        return n;
    endfunction

    function automatic void model_read(input int z, input int r,
                                       output logic [W-1:0] d, output logic rdy);
        int a;
        d = '0;
        rdy = 1'b0;
        if (!ren[r]) return;
        a = int'(raddr[r*AW +: AW]);
        if (has_zero(z) && a == 0) begin
            rdy = 1'b1;
            return;
        end
        d = m_data[z][a];
        rdy = !m_busy[z][a];
        if (has_bypass(z)) begin
            for (int w = NW - 1; w >= 0; w--) begin
                if (wen[w] && int'(waddr[w*AW +: AW]) == a) begin
                    d = wdata[w*W +: W];
                    rdy = 1'b1;
                    return;
                end
            end
        end
    endfunction

    // Entry-centric update: each entry takes the highest hitting write port, then
    // any allocate hit marks it busy.
    always @(posedge clk) begin
        if (rst) begin
            model_valid <= 1'b1;
            for (int z = 0; z < 2; z++) begin
                for (int e = 0; e < E; e++) begin
                    m_data[z][e] <= '0;
                    m_busy[z][e] <= 1'b0;
                end
            end
        end else begin
            for (int z = 0; z < 2; z++) begin
                for (int e = 0; e < E; e++) begin
                    if (!(has_zero(z) && e == 0)) begin
                        for (int w = 0; w < NW; w++) begin
                            if (wen[w] && int'(waddr[w*AW +: AW]) == e) begin
                                m_data[z][e] <= wdata[w*W +: W];
                                m_busy[z][e] <= 1'b0;
                            end
                        end
                        for (int a = 0; a < NA; a++) begin
                            if (aen[a] && int'(aaddr[a*AW +: AW]) == e) begin
                                m_busy[z][e] <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] ed;
        logic         er;
        if (model_valid) begin
            for (int z = 0; z < 2; z++) begin
                for (int r = 0; r < NR; r++) begin
                    model_read(z, r, ed, er);
                    chk($sformatf("cyc i%0d rd%0d data", z, r),
                        (z == 0) ? rd0[r*W +: W] : rd1[r*W +: W], ed);
                    chk($sformatf("cyc i%0d rd%0d ready", z, r),
                        32'((z == 0) ? rr0[r] : rr1[r]), 32'(er));
                end
                chk($sformatf("cyc i%0d busy_count", z),
                    32'((z == 0) ? bc0 : bc1), 32'(model_count(z)));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_en();
        wen = '0;
        aen = '0;
        ren = '0;
    endtask

    task automatic set_wr(input int p, input int a, input logic [W-1:0] d);
        wen[p] = 1'b1;
        waddr[p*AW +: AW] = AW'(a);
        wdata[p*W +: W] = d;
    endtask

    task automatic set_alloc(input int p, input int a);
        aen[p] = 1'b1;
        aaddr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_rd(input int p, input int a);
        ren[p] = 1'b1;
        raddr[p*AW +: AW] = AW'(a);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_en();
    endtask

    initial begin
        rst = 1'b1;
        waddr = '0;
        wdata = '0;
        aaddr = '0;
        raddr = '0;
        clear_en();
        step();
        step();
        rst = 1'b0;

        set_rd(0, 5);
        #1;
        chk("reset rd0 data", rd0[0*W +: W], 32'h0);
        chk("reset rd0 ready", 32'(rr0[0]), 32'd1);
        chk("reset busy_count", 32'(bc0), 32'd0);

        // Write entry 5, read back through the array.
        clear_en();
        set_wr(0, 5, 32'hDEADBEEF);
        step();
        set_rd(2, 5);
        #1;
        chk("wr5 rd2 data", rd0[2*W +: W], 32'hDEADBEEF);
        chk("wr5 rd2 ready", 32'(rr0[2]), 32'd1);
        chk("wr5 rd0 off data", rd0[0*W +: W], 32'h0);
        chk("wr5 rd0 off ready", 32'(rr0[0]), 32'd0);
        chk("wr5 i1 rd2 data", rd1[2*W +: W], 32'hDEADBEEF);

        // Allocate 7, then write it back with bypass.
        clear_en();
        set_alloc(0, 7);
        step();
        set_rd(1, 7);
        #1;
        chk("alloc7 ready", 32'(rr0[1]), 32'd0);
        chk("alloc7 busy_count", 32'(bc0), 32'd1);
        set_wr(0, 7, 32'h1234);
        #1;
        chk("bypass7 data", rd0[1*W +: W], 32'h1234);
        chk("bypass7 ready", 32'(rr0[1]), 32'd1);
        chk("nobypass7 i1 data", rd1[1*W +: W], 32'h0);
        chk("nobypass7 i1 ready", 32'(rr1[1]), 32'd0);
        step();
        set_rd(1, 7);
        #1;
        chk("wb7 busy_count", 32'(bc0), 32'd0);
        chk("wb7 i1 data", rd1[1*W +: W], 32'h1234);

        // Two write ports on entry 3: port 1 wins.
        clear_en();
        set_wr(0, 3, 32'hAAAA);
        set_wr(1, 3, 32'hBBBB);
        set_rd(0, 3);
        #1;
        chk("dual3 bypass data", rd0[0*W +: W], 32'hBBBB);
        step();
        set_rd(0, 3);
        #1;
        chk("dual3 array data", rd0[0*W +: W], 32'hBBBB);
        chk("dual3 i1 data", rd1[0*W +: W], 32'hBBBB);

        // Write and allocate entry 9 together: data written, entry stays busy.
        clear_en();
        set_wr(0, 9, 32'h99);
        set_alloc(0, 9);
        step();
        set_rd(0, 9);
        #1;
        chk("wa9 data", rd0[0*W +: W], 32'h99);
        chk("wa9 ready", 32'(rr0[0]), 32'd0);
        chk("wa9 busy_count", 32'(bc0), 32'd1);

        // Entry 0: hardwired in instance 1, ordinary in instance 0.
        clear_en();
        set_wr(0, 0, 32'hFFFF);
        set_alloc(0, 0);
        set_rd(0, 0);
        #1;
        chk("zero i1 same-cycle data", rd1[0*W +: W], 32'h0);
        chk("zero i1 same-cycle ready", 32'(rr1[0]), 32'd1);
        step();
        set_rd(0, 0);
        #1;
        chk("zero i1 data", rd1[0*W +: W], 32'h0);
        chk("zero i1 ready", 32'(rr1[0]), 32'd1);
        chk("zero i1 busy_count", 32'(bc1), 32'd1);
        chk("entry0 i0 data", rd0[0*W +: W], 32'hFFFF);
        chk("entry0 i0 ready", 32'(rr0[0]), 32'd0);
        chk("entry0 i0 busy_count", 32'(bc0), 32'd2);

        // Allocate every entry.
        for (int i = 0; i < E; i++) begin
            clear_en();
            set_alloc(0, i);
            step();
        end
        #1;
        chk("all busy i0 count", 32'(bc0), 32'd32);
        chk("all busy i1 count", 32'(bc1), 32'd31);

        // Mid-operation reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_rd(0, 5);
        set_rd(1, 31);
        set_rd(2, 0);
        #1;
        chk("post-rst busy_count", 32'(bc0), 32'd0);
        for (int r = 0; r < NR; r++) begin
            chk($sformatf("post-rst rd%0d data", r), rd0[r*W +: W], 32'h0);
            chk($sformatf("post-rst rd%0d ready", r), 32'(rr0[r]), 32'd1);
        end

        // Mixed traffic on a narrow address range to force collisions.
        for (int c = 0; c < 60; c++) begin
            clear_en();
            wen = NW'($urandom);
            for (int w = 0; w < NW; w++) begin
                waddr[w*AW +: AW] = AW'($urandom_range(0, 7));
                wdata[w*W +: W] = $urandom;
            end
            aen = NA'($urandom);
            aaddr = AW'($urandom_range(0, 7));
            ren = NR'($urandom);
            for (int r = 0; r < NR; r++) begin
                raddr[r*AW +: AW] = AW'($urandom_range(0, 7));
            end
            @(posedge clk);
            #1;
        end
        clear_en();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
